// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, captures {pc, instr} from a combinational imem
// into a small circular queue, and hands entries to decode over valid/ready.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int              PTR_W   = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]  CNT_ONE = (PTR_W + 1)'(1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] pc_mem_q    [QUEUE_DEPTH];
  logic [31:0] instr_mem_q [QUEUE_DEPTH];

  logic not_empty;
  logic pop;
  logic push;

  // Head is read combinationally so a freshly pushed entry is visible the next cycle.
  always_comb begin
    not_empty = (count_q != '0);
    out_valid = not_empty & ~redirect_valid;
    pop       = out_valid & out_ready;
    push      = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop);
    imem_addr = fetch_pc_q;
    out_pc    = not_empty ? pc_mem_q[rd_ptr_q]    : 32'h0;
    out_instr = not_empty ? instr_mem_q[rd_ptr_q] : 32'h0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Flush: drop every queued entry and restart at the aligned target.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

endmodule
